// File: rtl/ahb_req_arb_pkg.sv
// ============================================================================
// Module  : ahb_req_arb_pkg
// Brief   : Shared AHB encodings and sequencer state type for ahb_req_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_req_arb_pkg;

    // AHB transfer type encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Fixed transfer attributes: 32-bit words, single bursts, default protection
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0000;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

endpackage : ahb_req_arb_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker. Scans upward from
//           last_grant+1 with wrap-around and returns a one-hot grant plus
//           its index. Reusable by any shared-bus block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    // One extra bit so start+offset (at most 2*NUM_REQ-1) never overflows
    localparam int c_sum_w = IDX_W + 1;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [c_sum_w-1:0]   w_start;
    logic [c_sum_w-1:0]   w_sum;
    logic [c_sum_w-1:0]   w_idx;
    logic                 w_found;

    // Rotate the request vector so bit 0 is the highest-priority requester
    assign w_start   = c_sum_w'(last_grant) + c_sum_w'(1);
    assign w_req_dbl = {req, req};
    assign w_rot     = NUM_REQ'(w_req_dbl >> w_start);

    // First set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = w_start + c_sum_w'(k);
            end
        end
        w_idx     = (w_sum >= c_sum_w'(NUM_REQ)) ? (w_sum - c_sum_w'(NUM_REQ)) : w_sum;
        grant_idx = IDX_W'(w_idx);
        grant     = w_found ? (NUM_REQ'(1) << grant_idx) : '0;
        any       = w_found;
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/ahb_req_arbiter.sv
// ============================================================================
// Module  : ahb_req_arbiter
// Brief   : Round-robin sharing of one AHB-Lite master port between NUM_REQ
//           single-word requesters. Runs SINGLE/NONSEQ word transfers and
//           returns data/error with a one-cycle one-hot response pulse.
//           Optional macro AHB_REQ_ARB_TIMEOUT_EN adds a data-phase stall
//           timeout of TIMEOUT_CYCLES cycles that completes with an error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_req_arbiter
    import ahb_req_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ-1:0]     req_write_i,
    input  logic [NUM_REQ*32-1:0]  req_addr_i,
    input  logic [NUM_REQ*32-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [31:0]            HADDR,
    output logic [31:0]            HWDATA,
    output logic                   HWRITE,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic                   HMASTLOCK,
    input  logic [31:0]            HRDATA,
    input  logic                   HREADYOUT,
    input  logic                   HRESP
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    arb_state_t           r_state;
    logic [c_idx_w-1:0]   r_gnt_idx;
    logic [c_idx_w-1:0]   r_last_grant;
    logic                 r_write;
    logic [31:0]          r_wdata;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_idx_w-1:0]   w_gnt_idx;
    logic                 w_any;
    logic [31:0]          w_sel_addr;
    logic [31:0]          w_sel_wdata;
    logic                 w_sel_write;

`ifdef AHB_REQ_ARB_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_to_w-1:0]    r_to_cnt;
`else
    logic                 w_unused_to;
    assign w_unused_to = (TIMEOUT_CYCLES > 0);
`endif

    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .IDX_W      (c_idx_w)
    ) u_rr_arbiter (
        .req        (req_valid_i),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_gnt_idx),
        .any        (w_any)
    );

    // Accept strobe exists only while idle, so one transfer is ever in flight
    assign req_ready_o = (r_state == ST_IDLE) ? w_grant : '0;

    // Select the granted requester's command fields
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_idx == c_idx_w'(k)) begin
                w_sel_addr  = req_addr_i[32*k +: 32];
                w_sel_wdata = req_wdata_i[32*k +: 32];
                w_sel_write = req_write_i[k];
            end
        end
    end

    // Transfer sequencer: accept, address phase, data phase, respond
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_gnt_idx    <= '0;
            r_last_grant <= c_idx_w'(NUM_REQ - 1);
            r_write      <= 1'b0;
            r_wdata      <= '0;
            HADDR        <= '0;
            HWDATA       <= '0;
            HWRITE       <= 1'b0;
            HTRANS       <= HTRANS_IDLE;
            rsp_valid_o  <= '0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
`ifdef AHB_REQ_ARB_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            rsp_valid_o <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_write   <= w_sel_write;
                        r_wdata   <= w_sel_wdata;
                        HADDR     <= w_sel_addr;
                        HWRITE    <= w_sel_write;
                        HTRANS    <= HTRANS_NONSEQ;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADYOUT) begin
                        HTRANS  <= HTRANS_IDLE;
                        if (r_write) begin
                            HWDATA <= r_wdata;
                        end
`ifdef AHB_REQ_ARB_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HREADYOUT) begin
                        rsp_rdata_o  <= r_write ? 32'h0 : HRDATA;
                        rsp_err_o    <= HRESP;
                        rsp_valid_o  <= NUM_REQ'(1) << r_gnt_idx;
                        r_last_grant <= r_gnt_idx;
                        r_state      <= ST_IDLE;
                    end
`ifdef AHB_REQ_ARB_TIMEOUT_EN
                    else if (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1)) begin
                        // This stalled cycle brings the count to the limit
                        rsp_rdata_o  <= 32'h0;
                        rsp_err_o    <= 1'b1;
                        rsp_valid_o  <= NUM_REQ'(1) << r_gnt_idx;
                        r_last_grant <= r_gnt_idx;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_to_w'(1);
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ahb_req_arbiter

`default_nettype wire
